// File: rtl/dropout_pkg.sv
// Shared definitions for the forward dropout stage and its backward mask replay.
// Holds the default lane geometry, the gradient lane type and the saturating
// doubling used for inverted-dropout scaling at keep probability 0.5.
package dropout_pkg;

  localparam int N_NEUR_DEF = 8;
  localparam int GRAD_W_DEF = 8;

  typedef logic signed [GRAD_W_DEF-1:0] grad_lane_t;

  // Doubles a signed lane and clamps to the representable range.
  // Overflow happens exactly when the two top bits differ.
  function automatic grad_lane_t sat_shl1(grad_lane_t g);
    grad_lane_t r;
    if (g[GRAD_W_DEF-1] != g[GRAD_W_DEF-2]) begin
      r = g[GRAD_W_DEF-1] ? {1'b1, {(GRAD_W_DEF-1){1'b0}}}
                          : {1'b0, {(GRAD_W_DEF-1){1'b1}}};
    end else begin
      r = {g[GRAD_W_DEF-2:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/dropout_mask_fifo.sv
// Register FIFO holding forward dropout masks until their backward gradient
// arrives. push/pop must already be qualified by the caller's ready logic;
// flush discards any concurrent push/pop. Occupancy drives full/empty so the
// pointers can simply wrap modulo DEPTH (DEPTH is a power of two).
module dropout_mask_fifo #(
  parameter int N_NEUR = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [N_NEUR-1:0] push_mask,
  output logic [N_NEUR-1:0] head_mask,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [N_NEUR-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign head_mask = mem[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);

  // Mask storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_mask;
    end
  end

  // Pointers and occupancy; flush returns to the empty state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dropout_mask_replay.sv
// Backward-pass mask replay: forward dropout masks are queued, and each
// backward gradient vector is masked by the oldest one (dropped lanes -> 0).
// One-cycle latency through a single output register with valid/ready.
// Optional build macro: DROPOUT_REPLAY_SCALE_EN -- kept lanes are doubled with
// saturation (inverted dropout, keep prob 0.5). Scaling assumes GRAD_W equals
// the package lane width.
// Readies depend only on registered state so there is no valid->ready path;
// consequently a full FIFO refuses pushes even while popping, and an empty
// FIFO refuses pops even while being pushed.
module dropout_mask_replay
  import dropout_pkg::*;
#(
  parameter int N_NEUR = N_NEUR_DEF,
  parameter int GRAD_W = GRAD_W_DEF,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     flush,
  input  logic                     fwd_valid,
  output logic                     fwd_ready,
  input  logic [N_NEUR-1:0]        fwd_mask,
  input  logic                     bwd_valid,
  output logic                     bwd_ready,
  input  logic [N_NEUR*GRAD_W-1:0] bwd_grad,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_NEUR*GRAD_W-1:0] out_grad,
  output logic [N_NEUR-1:0]        out_mask,
  output logic [CNT_W-1:0]         mask_count
);

  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic [N_NEUR-1:0]        head_mask;
  logic [N_NEUR*GRAD_W-1:0] masked_grad;

  assign fwd_ready = ena && !full;
  assign bwd_ready = ena && !empty && (!out_valid || out_ready);
  assign push      = fwd_valid && fwd_ready;
  assign pop       = bwd_valid && bwd_ready;

  dropout_mask_fifo #(
    .N_NEUR (N_NEUR),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_mask (fwd_mask),
    .head_mask (head_mask),
    .count     (mask_count),
    .full      (full),
    .empty     (empty)
  );

  for (genvar i = 0; i < N_NEUR; i++) begin : g_lane
    logic [GRAD_W-1:0] lane_in;
    logic [GRAD_W-1:0] lane_kept;
    assign lane_in = bwd_grad[i*GRAD_W +: GRAD_W];
`ifdef DROPOUT_REPLAY_SCALE_EN
    assign lane_kept = GRAD_W'(sat_shl1(grad_lane_t'(lane_in)));
`else
    assign lane_kept = lane_in;
`endif
    assign masked_grad[i*GRAD_W +: GRAD_W] = head_mask[i] ? lane_kept : '0;
  end

  // Output register: load on pop, drop valid on accept, hold while stalled or frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
      out_mask  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
      out_mask  <= '0;
    end else if (ena) begin
      if (pop) begin
        out_valid <= 1'b1;
        out_grad  <= masked_grad;
        out_mask  <= head_mask;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dropout_mask_replay.sv
// Self-checking bench for dropout_mask_replay (default geometry 8 lanes x 8 bits,
// depth 4). A queue-based reference model predicts readies and the output
// register; directed steps cover the documented scenarios, then a random phase.
module tb_dropout_mask_replay;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena = 1'b1;
  logic        flush = 1'b0;
  logic        fwd_valid = 1'b0;
  logic        fwd_ready;
  logic [7:0]  fwd_mask = '0;
  logic        bwd_valid = 1'b0;
  logic        bwd_ready;
  logic [63:0] bwd_grad = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_grad;
  logic [7:0]  out_mask;
  logic [2:0]  mask_count;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0]  q[$];
  logic        m_ov = 1'b0;
  logic [63:0] m_og = '0;
  logic [7:0]  m_om = '0;
  logic [63:0] saved;

  dropout_mask_replay #(.N_NEUR(8), .GRAD_W(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_mask   (fwd_mask),
    .bwd_valid  (bwd_valid),
    .bwd_ready  (bwd_ready),
    .bwd_grad   (bwd_grad),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .out_mask   (out_mask),
    .mask_count (mask_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected lane value: kept lanes pass (or double with clamp), dropped lanes zero.
  function automatic logic [63:0] apply(input logic [63:0] g, input logic [7:0] m);
    logic [63:0] r;
    int v;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        v = int'($signed(g[i*8 +: 8]));
`ifdef DROPOUT_REPLAY_SCALE_EN
        v = v * 2;
        if (v > 127)  v = 127;
        if (v < -128) v = -128;
`endif
        r[i*8 +: 8] = v[7:0];
      end
    end
    return r;
  endfunction

  // One clock: check readies mid-cycle, advance the model, check registers after the edge.
  task automatic tick();
    logic exp_fr, exp_br, pu, po;
    @(negedge clk);
    exp_fr = ena && (q.size() < DEPTH);
    exp_br = ena && (q.size() > 0) && (!m_ov || out_ready);
    chk("fwd_ready", fwd_ready, exp_fr);
    chk("bwd_ready", bwd_ready, exp_br);
    pu = fwd_valid && exp_fr;
    po = bwd_valid && exp_br;
    if (flush) begin
      q.delete();
      m_ov = 1'b0; m_og = '0; m_om = '0;
    end else if (ena) begin
      if (po) begin
        m_om = q.pop_front();
        m_og = apply(bwd_grad, m_om);
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (pu) q.push_back(fwd_mask);
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_grad", out_grad, m_og);
    chk("out_mask", out_mask, m_om);
    chk("mask_count", mask_count, q.size());
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs must clear at once.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    fwd_valid = 1'b0; bwd_valid = 1'b0; flush = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_count", mask_count, 3'd0);
    chk("rst_out_grad", out_grad, 64'd0);
    chk("rst_out_mask", out_mask, 8'd0);
    chk("rst_bwd_ready", bwd_ready, 1'b0);
    chk("rst_fwd_ready", fwd_ready, ena);
    q.delete();
    m_ov = 1'b0; m_og = '0; m_om = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_masks(input int n);
    for (int i = 0; i < n; i++) begin
      fwd_valid = 1'b1;
      fwd_mask  = 8'($urandom);
      tick();
    end
    fwd_valid = 1'b0;
  endtask

  initial begin
    // 1: reset
    ena = 1'b1;
    do_reset();
    tick();

    // 2: single mask then gradient
    fwd_valid = 1'b1; fwd_mask = 8'hA5;
    tick();
    fwd_valid = 1'b0;
    bwd_valid = 1'b1; bwd_grad = {8{8'h10}}; out_ready = 1'b1;
    tick();
    bwd_valid = 1'b0;
`ifdef DROPOUT_REPLAY_SCALE_EN
    chk("t2_grad", out_grad, 64'h2000_2000_0020_0020);
`else
    chk("t2_grad", out_grad, 64'h1000_1000_0010_0010);
`endif
    chk("t2_mask", out_mask, 8'hA5);
    chk("t2_count", mask_count, 3'd0);
    tick();

    // 3: fill, then push+pop while full, then drain in order
    push_masks(4);
    chk("t3_full_ready", fwd_ready, 1'b0);
    fwd_valid = 1'b1; fwd_mask = 8'h3C;
    bwd_valid = 1'b1; bwd_grad = {$urandom, $urandom};
    tick();
    fwd_valid = 1'b0;
    chk("t3_count_after", mask_count, 3'd3);
    for (int i = 0; i < 3; i++) begin
      bwd_grad = {$urandom, $urandom};
      tick();
    end
    bwd_valid = 1'b0;
    tick();

    // 4: stall holds output, then back-to-back pops
    push_masks(3);
    bwd_valid = 1'b1; bwd_grad = {$urandom, $urandom}; out_ready = 1'b0;
    tick();
    saved = out_grad;
    for (int i = 0; i < 5; i++) begin
      bwd_grad = {$urandom, $urandom};
      tick();
      chk("t4_stable", out_grad, saved);
      chk("t4_bwd_ready", bwd_ready, 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bwd_grad = {$urandom, $urandom};
      tick();
    end
    bwd_valid = 1'b0;
    tick();

    // 5: flush with content, then reset mid-stream
    push_masks(4);
    bwd_valid = 1'b1; bwd_grad = {$urandom, $urandom}; out_ready = 1'b0;
    tick();
    bwd_valid = 1'b0;
    chk("t5_pre_count", mask_count, 3'd3);
    flush = 1'b1; fwd_valid = 1'b1; bwd_valid = 1'b1; out_ready = 1'b1; ena = 1'b0;
    tick();
    flush = 1'b0; fwd_valid = 1'b0; bwd_valid = 1'b0; ena = 1'b1;
    chk("t5_flush_count", mask_count, 3'd0);
    chk("t5_flush_valid", out_valid, 1'b0);
    push_masks(2);
    bwd_valid = 1'b1; bwd_grad = {$urandom, $urandom}; out_ready = 1'b0;
    tick();
    do_reset();
    out_ready = 1'b1;

    // 6: scaling corner lanes
    fwd_valid = 1'b1; fwd_mask = 8'hFF;
    tick();
    fwd_valid = 1'b0;
    bwd_valid = 1'b1; bwd_grad = 64'h0000_0000_90B0_5030;
    tick();
    bwd_valid = 1'b0;
`ifdef DROPOUT_REPLAY_SCALE_EN
    chk("t6_scale", out_grad, 64'h0000_0000_8080_7F60);
`else
    chk("t6_scale", out_grad, 64'h0000_0000_90B0_5030);
`endif
    tick();

    // ena=0 freeze with a pending output
    push_masks(2);
    bwd_valid = 1'b1; out_ready = 1'b0; bwd_grad = {$urandom, $urandom};
    tick();
    ena = 1'b0; out_ready = 1'b1; fwd_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("freeze_valid", out_valid, 1'b1);
    ena = 1'b1; fwd_valid = 1'b0; bwd_valid = 1'b0;
    tick();

    // random phase
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      ena       = ($urandom_range(0, 9) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      fwd_valid = 1'($urandom);
      fwd_mask  = 8'($urandom);
      bwd_valid = 1'($urandom);
      bwd_grad  = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
